adder_share_arbiter: RTL and testbench
======================================

ADDER_SHARE_ARBITER -- requirements
Module: adder_share_arbiter

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 24, operand/sum width.
REQ-002 SHALL have parameter NREQ, default 4, number of requesters (power of 2, 2..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester operation request.
REQ-006 SHALL have port req_ready  output  NREQ  per-requester grant/accept, one-hot or zero.
REQ-007 SHALL have port req_a  input  NREQ*BIT_WIDTH  operand A; requester i at bits [i*BIT_WIDTH +: BIT_WIDTH].
REQ-008 SHALL have port req_b  input  NREQ*BIT_WIDTH  operand B, same packing.
REQ-009 SHALL have port cfg_exact  input  NREQ  per-requester mode: 1 = exact add, 0 = approximate core.
REQ-010 SHALL have port res_valid  output  1  result register holds a valid result.
REQ-011 SHALL have port res_ready  input  1  consumer accepts result.
REQ-012 SHALL have port res_sum  output  BIT_WIDTH  sum.
REQ-013 SHALL have port res_cout  output  1  carry out.
REQ-014 SHALL have port res_id  output  log2(NREQ)  index of requester owning the result.
REQ-015 SHALL have port op_count  output  16  number of accepted operations, saturating.

Function
REQ-016 SHALL share one instance of the team's 24-bit approximate adder core (ports A, B, Cin, S, Cout), Cin tied 0, and one exact adder; selection by cfg_exact of granted requester sampled at accept.
REQ-017 SHALL implement a 2-state FSM on the result register: EMPTY (res_valid=0), FULL (res_valid=1).
REQ-018 SHALL compute can_accept = EMPTY or (FULL and res_ready) combinationally.
REQ-019 SHALL assert at most one req_ready bit, only when can_accept and that requester's req_valid is high; req_ready SHALL never assert for a non-requesting index.
REQ-020 SHALL pick the grant round-robin: search starts at (last_grant+1) mod NREQ, first req_valid found wins.
REQ-021 SHALL update last_grant to the granted index only on an accept (req_valid[i] and req_ready[i]); no accept leaves last_grant unchanged.
REQ-022 SHALL register sum, cout and id on accept; result visible on res_* exactly 1 cycle after the accept edge (latency 1).
REQ-023 SHALL transition EMPTY->FULL on accept; FULL->EMPTY on res_ready with no accept; FULL->FULL with new data on res_ready and accept in same cycle (full throughput, 1 op/cycle).
REQ-024 SHALL hold res_sum, res_cout, res_id stable while FULL and res_ready=0.
REQ-025 SHALL compute exact mode as {res_cout,res_sum} = a + b at BIT_WIDTH+1 bits, wrap-around in res_sum.
REQ-026 SHALL increment op_count on each accept, saturating at 16'hFFFF.
REQ-027 SHALL ignore req_a/req_b/cfg_exact changes of non-granted requesters; changes of cfg_exact SHALL not affect a result already registered.
REQ-028 SHALL allow a requester to hold req_valid across cycles; request retracted before grant is legal and simply not served.

Reset
REQ-029 SHALL, when rst_n=0 at a clock edge, force state EMPTY, res_valid=0, res_sum=0, res_cout=0, res_id=0, op_count=0, last_grant=NREQ-1 (so requester 0 has top priority first).
REQ-030 SHALL drive req_ready=0 while rst_n=0; reset mid-operation SHALL discard any held result without a res_valid pulse.

Verification
REQ-031 Single request: after reset, req_valid=0001, a=0xFFFFFF, b=0x000001, cfg_exact=1 -> req_ready=0001 same cycle; next cycle res_valid=1, res_sum=0x000000, res_cout=1, res_id=0, op_count=1.
REQ-032 Round-robin: req_valid=1111 held, res_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles, one result per cycle, res_id following same order.
REQ-033 Backpressure: res_ready=0 with result held, req_valid=0010 -> req_ready=0000, res_* unchanged for 5 cycles; res_ready=1 -> grant 1 same cycle, new result next cycle.
REQ-034 Mode mix: req 2 cfg_exact=1, req 3 cfg_exact=0, both a=0x123456, b=0x654321 -> req 2 res_sum=0x777777 exactly; req 3 result equals standalone approximate core output for same operands.
REQ-035 Reset mid-operation: res_valid=1, rst_n=0 for one edge -> res_valid=0, op_count=0; req_valid=1000|0001 afterwards -> requester 0 granted first.
REQ-036 Saturation: 65537 accepted operations -> op_count=0xFFFF, stays 0xFFFF.

Source files
------------

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one approximate adder core and one exact adder
// among NREQ requesters, with a single-entry registered result stage.

module approx_adder_core #(
  parameter int WIDTH = 24,
  parameter int LOWER = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);
  // Lower-part OR adder: low bits are A|B, the top bit pair of the low part
  // feeds a speculative carry into the exact upper adder.
  logic                 w_carry;
  logic [WIDTH-LOWER:0] w_hi;

  assign w_carry = (A[LOWER-1] & B[LOWER-1]) | Cin;
  assign w_hi    = {1'b0, A[WIDTH-1:LOWER]} + {1'b0, B[WIDTH-1:LOWER]}
                 + {{(WIDTH-LOWER){1'b0}}, w_carry};
  assign S       = {w_hi[WIDTH-LOWER-1:0], A[LOWER-1:0] | B[LOWER-1:0]};
  assign Cout    = w_hi[WIDTH-LOWER];
endmodule

module asa_lane #(
  parameter int IDW = 2,
  parameter int IDX = 0
) (
  input  logic           i_accept,
  input  logic [IDW-1:0] i_gnt,
  output logic           o_ready
);
  assign o_ready = i_accept && (i_gnt == IDW'(IDX));
endmodule

module adder_share_arbiter #(
  parameter int BIT_WIDTH = 24,
  parameter int NREQ      = 4,
  localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*BIT_WIDTH-1:0] req_a,
  input  logic [NREQ*BIT_WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]           cfg_exact,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [BIT_WIDTH-1:0]      res_sum,
  output logic                      res_cout,
  output logic [IDW-1:0]            res_id,
  output logic [15:0]               op_count
);
  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t               r_state;
  logic [IDW-1:0]       r_last;
  logic [BIT_WIDTH-1:0] r_sum;
  logic                 r_cout;
  logic [IDW-1:0]       r_id;
  logic [15:0]          r_op_count;

  logic [NREQ-1:0][BIT_WIDTH-1:0] w_a_lane;
  logic [NREQ-1:0][BIT_WIDTH-1:0] w_b_lane;
  logic [BIT_WIDTH-1:0] w_a, w_b;
  logic [BIT_WIDTH-1:0] w_apx_sum;
  logic                 w_apx_cout;
  logic [BIT_WIDTH:0]   w_exact;
  logic                 w_can_accept;
  logic                 w_found;
  logic [IDW-1:0]       w_gnt;
  logic                 w_accept;
  logic                 w_sel_exact;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      assign w_a_lane[gi] = req_a[gi*BIT_WIDTH +: BIT_WIDTH];
      assign w_b_lane[gi] = req_b[gi*BIT_WIDTH +: BIT_WIDTH];
      asa_lane #(.IDW(IDW), .IDX(gi)) u_lane (
        .i_accept (w_accept),
        .i_gnt    (w_gnt),
        .o_ready  (req_ready[gi])
      );
    end
  endgenerate

  assign w_can_accept = (r_state == S_EMPTY) || res_ready;

  // Search from last_grant+1; wrap is free because NREQ is a power of two.
  always_comb begin
    logic [IDW-1:0] cand;
    w_found = 1'b0;
    w_gnt   = r_last;
    cand    = r_last;
    for (int k = 1; k <= NREQ; k++) begin
      cand = r_last + IDW'(k);
      if (!w_found && req_valid[cand]) begin
        w_found = 1'b1;
        w_gnt   = cand;
      end
    end
  end

  assign w_accept    = rst_n && w_can_accept && w_found;
  assign w_a         = w_a_lane[w_gnt];
  assign w_b         = w_b_lane[w_gnt];
  assign w_sel_exact = cfg_exact[w_gnt];
  assign w_exact     = {1'b0, w_a} + {1'b0, w_b};

  approx_adder_core #(.WIDTH(BIT_WIDTH)) u_apx (
    .A    (w_a),
    .B    (w_b),
    .Cin  (1'b0),
    .S    (w_apx_sum),
    .Cout (w_apx_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_EMPTY;
      r_last     <= IDW'(NREQ-1);
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_id       <= '0;
      r_op_count <= '0;
    end else if (w_accept) begin
      r_state <= S_FULL;
      r_last  <= w_gnt;
      r_id    <= w_gnt;
      r_sum   <= w_sel_exact ? w_exact[BIT_WIDTH-1:0] : w_apx_sum;
      r_cout  <= w_sel_exact ? w_exact[BIT_WIDTH]     : w_apx_cout;
      if (r_op_count != 16'hFFFF) r_op_count <= r_op_count + 16'd1;
    end else if (r_state == S_FULL && res_ready) begin
      r_state <= S_EMPTY;
    end
  end

  assign res_valid = (r_state == S_FULL);
  assign res_sum   = r_sum;
  assign res_cout  = r_cout;
  assign res_id    = r_id;
  assign op_count  = r_op_count;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: reset, round-robin, backpressure,
// exact/approximate mode mix, mid-operation reset and counter saturation.

module tb_adder_share_arbiter;
  localparam int BW = 24;
  localparam int N  = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*BW-1:0] req_a, req_b;
  logic [N-1:0]    cfg_exact;
  logic            res_valid, res_ready, res_cout;
  logic [BW-1:0]   res_sum;
  logic [1:0]      res_id;
  logic [15:0]     op_count;

  int checks = 0;
  int errors = 0;

  adder_share_arbiter #(.BIT_WIDTH(BW), .NREQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .cfg_exact(cfg_exact),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_cout(res_cout), .res_id(res_id), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [23:0] sum, input logic cout,
                         input logic [1:0] id);
    chk({tag, ".valid"}, 32'(res_valid), 32'd1);
    chk({tag, ".sum"},   32'(res_sum),   32'(sum));
    chk({tag, ".cout"},  32'(res_cout),  32'(cout));
    chk({tag, ".id"},    32'(res_id),    32'(id));
  endtask

  initial begin
    logic [1:0] g;
    rst_n = 1'b0; req_valid = '1; res_ready = 1'b0;
    req_a = '0; req_b = '0; cfg_exact = '1;
    #1;
    chk("ready_in_reset", 32'(req_ready), 32'h0);
    tick(); tick();
    chk("rst.valid", 32'(res_valid), 32'd0);
    chk("rst.sum",   32'(res_sum),   32'd0);
    chk("rst.cout",  32'(res_cout),  32'd0);
    chk("rst.id",    32'(res_id),    32'd0);
    chk("rst.count", 32'(op_count),  32'd0);
    chk("ready_in_reset2", 32'(req_ready), 32'h0);

    // Single request: exact wrap with carry out
    rst_n = 1'b1; req_valid = 4'b0001;
    req_a[0*BW +: BW] = 24'hFFFFFF; req_b[0*BW +: BW] = 24'h000001;
    #1;
    chk("single.ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    chk_res("single", 24'h000000, 1'b1, 2'd0);
    chk("single.count", 32'(op_count), 32'd1);

    // Round-robin from a fresh reset
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_a[i*BW +: BW] = 24'(32'h100 * i);
      req_b[i*BW +: BW] = 24'h000001;
    end
    req_valid = 4'b1111; res_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      g = 2'(k);
      #1;
      chk("rr.ready", 32'(req_ready), 32'(1 << g));
      tick();
      if (k == 5) begin req_valid = 4'b0010; res_ready = 1'b0; end
      chk_res("rr", 24'(32'h100 * g + 1), 1'b0, g);
    end
    chk("rr.count", 32'(op_count), 32'd6);

    // Backpressure: result held, requester 1 waits
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp.ready", 32'(req_ready), 32'h0);
      tick();
      chk_res("bp.hold", 24'h000101, 1'b0, 2'd1);
    end
    req_a[1*BW +: BW] = 24'h000500; req_b[1*BW +: BW] = 24'h000005;
    res_ready = 1'b1;
    #1;
    chk("bp.ready_release", 32'(req_ready), 32'h2);
    tick();
    chk_res("bp.new", 24'h000505, 1'b0, 2'd1);
    chk("bp.count", 32'(op_count), 32'd7);

    // Mode mix: requester 2 exact, requester 3 approximate
    cfg_exact = 4'b0100;
    req_a[2*BW +: BW] = 24'h123456; req_b[2*BW +: BW] = 24'h654321;
    req_a[3*BW +: BW] = 24'h123456; req_b[3*BW +: BW] = 24'h654321;
    req_valid = 4'b1100;
    #1;
    chk("mix.ready2", 32'(req_ready), 32'h4);
    tick();
    chk_res("mix.exact", 24'h777777, 1'b0, 2'd2);
    chk("mix.ready3", 32'(req_ready), 32'h8);
    tick();
    chk_res("mix.approx", 24'h777777, 1'b0, 2'd3);
    // Operands where OR-based low part differs from a true add
    req_a[3*BW +: BW] = 24'h000080; req_b[3*BW +: BW] = 24'h000080;
    req_valid = 4'b1000;
    tick();
    chk_res("mix.approx80", 24'h000180, 1'b0, 2'd3);
    cfg_exact[3] = 1'b1; res_ready = 1'b0; req_valid = '0;
    tick();
    chk_res("mix.cfg_after", 24'h000180, 1'b0, 2'd3);
    res_ready = 1'b1; req_valid = 4'b1000;
    tick();
    chk_res("mix.exact80", 24'h000100, 1'b0, 2'd3);
    chk("mix.count", 32'(op_count), 32'd11);
    req_valid = '0;
    tick();
    chk("drain.valid", 32'(res_valid), 32'd0);

    // Reset while holding a result
    req_valid = 4'b0010; res_ready = 1'b0;
    tick();
    req_valid = '0;
    chk("mid.valid_before", 32'(res_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mid.valid", 32'(res_valid), 32'd0);
    chk("mid.count", 32'(op_count),  32'd0);
    rst_n = 1'b1; req_valid = 4'b1001; res_ready = 1'b1;
    #1;
    chk("mid.ready0", 32'(req_ready), 32'h1);
    tick();
    chk("mid.id", 32'(res_id), 32'd0);
    chk("mid.count1", 32'(op_count), 32'd1);

    // Saturation of the operation counter
    req_valid = 4'b1111;
    repeat (65533) tick();
    chk("sat.fffe", 32'(op_count), 32'h0000FFFE);
    repeat (3) tick();
    chk("sat.ffff", 32'(op_count), 32'h0000FFFF);
    tick();
    chk("sat.hold", 32'(op_count), 32'h0000FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
